// File: rtl/rapid_pkg.sv
// Shared core definitions: datapath width, RV32M op encodings, muldiv FSM states
// and the multiply helper used by the M-extension unit.
package rapid_pkg;
  localparam int XLEN           = 32;
  localparam int DIV_ITERATIONS = XLEN;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } muldiv_state_e;

  // Operands are widened by one sign/zero bit so a single signed 66-bit product
  // covers the signed, mixed and unsigned variants.
  function automatic logic [XLEN-1:0] mul_result(input logic [2:0] f3,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic [2*XLEN+1:0] pa;
    logic [2*XLEN+1:0] pb;
    logic [2*XLEN+1:0] p;
    logic              sa;
    logic              sb;
    sa = ((f3 == MULH) || (f3 == MULHSU)) && a[XLEN-1];
    sb = (f3 == MULH) && b[XLEN-1];
    pa = {{(XLEN+2){sa}}, a};
    pb = {{(XLEN+2){sb}}, b};
    p  = pa * pb;
    return (f3 == MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction
endpackage

// File: rtl/div_iter_core.sv
// Unsigned restoring radix-2 divider; the start edge performs the first of
// DIV_ITERATIONS steps, the remaining ones follow one per cycle.
module div_iter_core
  import rapid_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int CW = $clog2(DIV_ITERATIONS);

  logic [XLEN-1:0] quo_reg, rem_reg, dsr_reg;
  logic [CW-1:0]   cnt_reg;
  logic            active_reg;

  logic [XLEN-1:0] quo_in, rem_in, dsr_in, quo_next, rem_next;
  logic [XLEN:0]   trial;

  always_comb begin
    quo_in = start ? dividend : quo_reg;
    rem_in = start ? '0 : rem_reg;
    dsr_in = start ? divisor : dsr_reg;
    trial  = {rem_in, quo_in[XLEN-1]} - {1'b0, dsr_in};
    // Top bit of trial set means the shifted remainder was smaller: restore.
    if (!trial[XLEN]) begin
      rem_next = trial[XLEN-1:0];
      quo_next = {quo_in[XLEN-2:0], 1'b1};
    end else begin
      rem_next = {rem_in[XLEN-2:0], quo_in[XLEN-1]};
      quo_next = {quo_in[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_reg    <= '0;
      rem_reg    <= '0;
      dsr_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
    end else if (abort) begin
      cnt_reg    <= '0;
      active_reg <= 1'b0;
    end else if (start) begin
      quo_reg    <= quo_next;
      rem_reg    <= rem_next;
      dsr_reg    <= dsr_in;
      cnt_reg    <= CW'(DIV_ITERATIONS - 1);
      active_reg <= 1'b1;
    end else if (active_reg) begin
      if (cnt_reg != '0) begin
        quo_reg <= quo_next;
        rem_reg <= rem_next;
        cnt_reg <= cnt_reg - 1'b1;
      end else begin
        active_reg <= 1'b0;
      end
    end
  end

  assign done      = active_reg && (cnt_reg == '0);
  assign quotient  = quo_reg;
  assign remainder = rem_reg;
endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute unit: multi-cycle multiply/divide with issue and writeback
// valid/ready handshakes, flush, and busy/pending-rd reporting for hazard stalls.
module muldiv_unit
  import rapid_pkg::*;
#(
  parameter int MUL_LATENCY = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic [4:0]      i_rd,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_wb_ready,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy,
  output logic [4:0]      o_busy_rd
);
  muldiv_state_e   state_reg;
  logic [2:0]      funct3_reg;
  logic [4:0]      rd_reg;
  logic [XLEN-1:0] a_reg, b_reg, result_reg;
  logic            a_neg_reg, b_neg_reg;
  logic [1:0]      mul_cnt_reg;

  logic            accept, is_mul, is_rem, signed_op, in_a_neg, in_b_neg;
  logic            div_by_zero, overflow, div_start, div_done;
  logic [XLEN-1:0] mag_a, mag_b, special_result, quotient, remainder;
  logic [XLEN-1:0] q_fix, r_fix, div_result;

  assign o_ready     = (state_reg == ST_IDLE) && !i_flush;
  assign accept      = i_valid && o_ready;
  assign is_mul      = !i_funct3[2];
  assign is_rem      = i_funct3[1];
  assign signed_op   = (i_funct3 == DIV) || (i_funct3 == REM);
  assign in_a_neg    = signed_op && i_rs1_data[XLEN-1];
  assign in_b_neg    = signed_op && i_rs2_data[XLEN-1];
  assign div_by_zero = (i_rs2_data == '0);
  assign overflow    = signed_op && (i_rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                       && (i_rs2_data == '1);
  assign mag_a       = in_a_neg ? -i_rs1_data : i_rs1_data;
  assign mag_b       = in_b_neg ? -i_rs2_data : i_rs2_data;
  assign div_start   = accept && !is_mul && !div_by_zero && !overflow;

  // Divide-by-zero and signed overflow never reach the iterator.
  assign special_result = div_by_zero ? (is_rem ? i_rs1_data : '1)
                                      : (is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}});

  assign q_fix      = (a_neg_reg ^ b_neg_reg) ? -quotient : quotient;
  assign r_fix      = a_neg_reg ? -remainder : remainder;
  assign div_result = funct3_reg[1] ? r_fix : q_fix;

  div_iter_core u_div (
    .clk       (i_clk),
    .rst       (i_reset),
    .start     (div_start),
    .abort     (i_flush),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg   <= ST_IDLE;
      funct3_reg  <= '0;
      rd_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      a_neg_reg   <= 1'b0;
      b_neg_reg   <= 1'b0;
      mul_cnt_reg <= '0;
      result_reg  <= '0;
    end else if (i_flush) begin
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (accept) begin
          funct3_reg <= i_funct3;
          rd_reg     <= i_rd;
          a_reg      <= i_rs1_data;
          b_reg      <= i_rs2_data;
          a_neg_reg  <= in_a_neg;
          b_neg_reg  <= in_b_neg;
          if (is_mul) begin
            if (MUL_LATENCY == 1) begin
              result_reg <= mul_result(i_funct3, i_rs1_data, i_rs2_data);
              state_reg  <= ST_DONE;
            end else begin
              mul_cnt_reg <= 2'(MUL_LATENCY - 2);
              state_reg   <= ST_MUL;
            end
          end else if (div_by_zero || overflow) begin
            result_reg <= special_result;
            state_reg  <= ST_DONE;
          end else begin
            state_reg <= ST_DIV;
          end
        end
        ST_MUL: begin
          if (mul_cnt_reg == '0) begin
            result_reg <= mul_result(funct3_reg, a_reg, b_reg);
            state_reg  <= ST_DONE;
          end else begin
            mul_cnt_reg <= mul_cnt_reg - 1'b1;
          end
        end
        ST_DIV: if (div_done) begin
          result_reg <= div_result;
          state_reg  <= ST_DONE;
        end
        ST_DONE: if (i_wb_ready) state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_valid   = (state_reg == ST_DONE);
  assign o_busy    = (state_reg != ST_IDLE);
  assign o_busy_rd = o_busy ? rd_reg : 5'd0;
  assign o_rd      = rd_reg;
  assign o_result  = result_reg;
endmodule
